// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - UART transmitter that drains a synchronous FIFO
//
// Pops one byte per frame through the FIFO read port and serialises it as
// start bit, LSB-first data, optional even parity and 1 or 2 stop bits.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   enable       allows a new fetch; only looked at in IDLE
//   fifo_empty   FIFO empty flag
//   fifo_rd_data FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en   single-cycle FIFO pop strobe (high during FETCH)
//   tx           serial line, idles high
//   busy         high whenever the FSM is not in IDLE
//   tx_done      one-cycle pulse on the last cycle of the final stop bit
//   frame_count  frames completed since reset, wraps
module fifo_uart_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 868,
   parameter int PARITY_EN    = 0,
   parameter int STOP_BITS    = 1,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  fifo_rd_en,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done,
   output logic [CNT_WIDTH-1:0]  frame_count
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                state_q, state_d;
   logic [BAUD_W-1:0]     baud_q, baud_d;
   logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  parity_q, parity_d;
   logic [CNT_WIDTH-1:0]  frame_count_q, frame_count_d;
   logic                  tx_q, tx_d;
   logic                  fifo_rd_en_q, fifo_rd_en_d;
   logic                  busy_q, busy_d;
   logic                  tx_done_q, tx_done_d;

   logic baud_last;

   assign baud_last = (baud_q == BAUD_LAST);

   always_comb begin
      state_d       = state_q;
      baud_d        = baud_q + 1'b1;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      parity_d      = parity_q;
      frame_count_d = frame_count_q;

      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            if (enable && !fifo_empty) begin
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = S_LOAD;
         end
         S_LOAD: begin
            // The FIFO presents the popped word this cycle.
            shift_d  = fifo_rd_data;
            parity_d = ^fifo_rd_data;
            state_d  = S_START;
         end
         S_START: begin
            if (baud_last) begin
               bit_cnt_d = '0;
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_last) begin
               baud_d = '0;
               if (bit_cnt_q == DATA_LAST) begin
                  bit_cnt_d = '0;
                  state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (baud_last) begin
               bit_cnt_d = '0;
               state_d   = S_STOP;
            end
         end
         S_STOP: begin
            // bit_cnt indexes the stop bit when two are configured.
            if (baud_last) begin
               baud_d = '0;
               if (bit_cnt_q == STOP_LAST) begin
                  bit_cnt_d     = '0;
                  frame_count_d = frame_count_q + 1'b1;
                  state_d       = S_IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_d != state_q) begin
         baud_d = '0;
      end

      // Outputs are decoded from the next state so that the registered
      // values line up with the state they belong to.
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[bit_cnt_d];
         S_PARITY: tx_d = parity_d;
         default:  tx_d = 1'b1;
      endcase
      fifo_rd_en_d = (state_d == S_FETCH);
      busy_d       = (state_d != S_IDLE);
      // Raised one cycle early so the registered pulse covers the last cycle.
      tx_done_d    = (state_q == S_STOP) && (bit_cnt_q == STOP_LAST) &&
                     (baud_q == BAUD_PRE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         baud_q        <= '0;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         parity_q      <= 1'b0;
         frame_count_q <= '0;
         tx_q          <= 1'b1;
         fifo_rd_en_q  <= 1'b0;
         busy_q        <= 1'b0;
         tx_done_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         baud_q        <= baud_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         parity_q      <= parity_d;
         frame_count_q <= frame_count_d;
         tx_q          <= tx_d;
         fifo_rd_en_q  <= fifo_rd_en_d;
         busy_q        <= busy_d;
         tx_done_q     <= tx_done_d;
      end
   end

   assign tx          = tx_q;
   assign fifo_rd_en  = fifo_rd_en_q;
   assign busy        = busy_q;
   assign tx_done     = tx_done_q;
   assign frame_count = frame_count_q;

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Serial transmit stage that sits directly downstream of the synchronous FIFO.
- Pops one byte at a time through the FIFO read port and serialises it as a UART frame: start bit, LSB-first data, optional even parity, then stop bit(s).
- Drains the FIFO continuously while enabled, and reports frame completion and busy status to the system controller.

Parameters:
- DATA_WIDTH, 8, data bits per frame; must equal the FIFO data width.
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200 baud); must be >= 2.
- PARITY_EN, 0, 1 inserts an even-parity bit after the data bits.
- STOP_BITS, 1, number of stop bits; legal values are 1 or 2.
- CNT_WIDTH, 16, width of the frame counter.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- enable  input  1  permits fetching a new byte; sampled only in IDLE
- fifo_empty  input  1  FIFO empty flag
- fifo_rd_data  input  DATA_WIDTH  FIFO read data; valid the cycle after fifo_rd_en
- fifo_rd_en  output  1  FIFO read strobe; single-cycle pulse
- tx  output  1  serial line; idles high
- busy  output  1  high whenever state != IDLE
- tx_done  output  1  one-cycle pulse when the final stop bit ends
- frame_count  output  CNT_WIDTH  frames completed since reset; wraps

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values: state=IDLE, tx=1, fifo_rd_en=0, busy=0, tx_done=0, frame_count=0, bit counter=0, baud counter=0.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE -> FETCH when enable=1 and fifo_empty=0 at the clock edge. Otherwise stay in IDLE with tx=1.
- FETCH: lasts exactly 1 cycle; fifo_rd_en=1 only in this state. This is a Moore decode, glitch-free. Next state is LOAD.
- LOAD: lasts 1 cycle; fifo_rd_data (registered by the FIFO) is captured into the shift register and the parity register (XOR of all data bits). Next state is START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: sends DATA_WIDTH bits LSB first, each held CLKS_PER_BIT cycles.
- PARITY: entered only if PARITY_EN=1. Sends the even-parity bit for CLKS_PER_BIT cycles.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the last cycle: tx_done=1, frame_count increments, next state is IDLE.
- tx is registered, so there are no combinational glitches on the line.
- Baud counter counts 0..CLKS_PER_BIT-1 and clears on every state change. Bit counter counts 0..DATA_WIDTH-1.
- Back-to-back frames: minimum idle-high gap between one frame's stop bit(s) and the next start bit is exactly 3 cycles (IDLE, FETCH, LOAD).
- Boundary rules:
  - fifo_empty=1 in IDLE: no fifo_rd_en is ever issued.
  - fifo_empty is ignored outside IDLE; no second read is issued during a frame.
  - enable deasserted mid-frame: the current frame completes normally and no further fetch occurs.
  - enable changing during FETCH or LOAD has no effect; the popped byte is always transmitted.
  - Reset mid-frame: tx returns to 1 immediately (asynchronously) and the popped byte is discarded. No partial-frame recovery.
  - frame_count wraps from 2^CNT_WIDTH-1 to 0.
- Frame length in cycles = (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) * CLKS_PER_BIT.

Test Plan:
- All scenarios use CLKS_PER_BIT=4 and DATA_WIDTH=8.
- Reset held with FIFO non-empty -> tx=1, fifo_rd_en=0, busy=0, frame_count=0 throughout.
- FIFO holds 0xA5, PARITY_EN=0, STOP_BITS=1, enable=1:
  - exactly one fifo_rd_en pulse;
  - tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40-cycle frame);
  - tx_done pulses on the last stop cycle; frame_count=1.
- PARITY_EN=1, STOP_BITS=2, bytes 0xA5 then 0x07:
  - parity bits are 0 then 1;
  - frames are 48 cycles each;
  - gap between the second stop bit's end and the next start bit is exactly 3 cycles;
  - frame_count=2.
- enable dropped during the DATA state of byte 0x3C with 0x11 still queued -> 0x3C completes, no further fifo_rd_en, tx stays 1, busy=0.
- rst asserted mid-DATA -> tx=1 in the same cycle, state IDLE. After release with enable=1 and FIFO non-empty, the next byte is fetched and sent cleanly.
- fifo_empty=1 with enable=1 for 100 cycles -> no fifo_rd_en, busy=0, tx=1.
